uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `uart_tx` transmitter among `N_REQ` requesters, each supplying its own byte and frame format. It sits between the requesting blocks and `uart_tx`. It accepts one request at a time and latches its data and frame configuration. It then issues a single `tx_start`, waits for `tx_done_tick`, enforces an idle-line gap, and reports completion or a watchdog timeout per requester.

---
 rtl/uart_tx_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx among N_REQ requesters.
// Latches the winner's byte and frame format, then sequences start/done/timeout and an idle gap.
module uart_tx_arbiter #(
    parameter int N_REQ         = 4,
    parameter int GAP_TICKS     = 16,
    parameter int TIMEOUT_TICKS = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [8*N_REQ-1:0]       req_data,
    input  logic [3*N_REQ-1:0]       req_dbit,
    input  logic [2*N_REQ-1:0]       req_sbit,
    input  logic [2*N_REQ-1:0]       req_parity,
    output logic [N_REQ-1:0]         req_ready,
    output logic [N_REQ-1:0]         req_done,
    input  logic                     s_tick,
    input  logic                     tx_done_tick,
    output logic                     tx_start,
    output logic [7:0]               tx_din,
    output logic [2:0]               dbit_select_o,
    output logic [1:0]               sbit_select_o,
    output logic [1:0]               parity_select_o,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     timeout_err
);

    localparam int GW    = $clog2(N_REQ);
    localparam int WD_W  = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
    localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_TICKS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [GW:0]      N_W      = (GW+1)'(N_REQ);

    typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_GAP} state_t;

    localparam state_t AFTER_FRAME = (GAP_TICKS == 0) ? S_IDLE : S_GAP;

    state_t            state_q, state_d;
    logic [GW-1:0]     last_grant_q, last_grant_d;
    logic [GW-1:0]     grant_id_q, grant_id_d;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [N_REQ-1:0]  req_ready_q, req_ready_d;
    logic [N_REQ-1:0]  req_done_q, req_done_d;
    logic              tx_start_q, tx_start_d;
    logic              busy_q, busy_d;
    logic              timeout_err_q, timeout_err_d;
    logic [7:0]        tx_din_q, tx_din_d;
    logic [2:0]        dbit_q, dbit_d;
    logic [1:0]        sbit_q, sbit_d;
    logic [1:0]        parity_q, parity_d;

    logic              found;
    logic [GW:0]       cand;
    logic [GW-1:0]     win;
    logic [2:0]        win_dbit;
    logic [1:0]        win_sbit;
    logic [1:0]        win_parity;

    // Round-robin search starting just after the last grant; first valid hit wins.
    always_comb begin
        found = 1'b0;
        cand  = '0;
        win   = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = {1'b0, last_grant_q} + (GW+1)'(off);
            if (cand >= N_W) begin
                cand = cand - N_W;
            end
            if (!found && req_valid[cand[GW-1:0]]) begin
                found = 1'b1;
                win   = cand[GW-1:0];
            end
        end
        win_dbit   = req_dbit[3*win +: 3];
        win_sbit   = req_sbit[2*win +: 2];
        win_parity = req_parity[2*win +: 2];
    end

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_id_d    = grant_id_q;
        wd_cnt_d      = wd_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        tx_din_d      = tx_din_q;
        dbit_d        = dbit_q;
        sbit_d        = sbit_q;
        parity_d      = parity_q;
        req_ready_d   = '0;
        req_done_d    = '0;
        tx_start_d    = 1'b0;
        timeout_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d          = S_START;
                    req_ready_d[win] = 1'b1;
                    grant_id_d       = win;
                    last_grant_d     = win;
                    tx_start_d       = 1'b1;
                    tx_din_d         = req_data[8*win +: 8];
                    // Illegal encodings are folded onto the nearest legal frame format.
                    dbit_d           = win_dbit[2] ? 3'b011 : win_dbit;
                    sbit_d           = (win_sbit == 2'b11) ? 2'b10 : win_sbit;
                    parity_d         = (win_parity == 2'b11) ? 2'b00 : win_parity;
                end
            end
            S_START: begin
                wd_cnt_d = '0;
                state_d  = S_BUSY;
            end
            S_BUSY: begin
                // A done arriving on the final watchdog tick still counts as success.
                if (tx_done_tick) begin
                    req_done_d[grant_id_q] = 1'b1;
                    gap_cnt_d              = '0;
                    state_d                = AFTER_FRAME;
                end else if (s_tick) begin
                    if (wd_cnt_q == WD_LAST) begin
                        timeout_err_d = 1'b1;
                        gap_cnt_d     = '0;
                        state_d       = AFTER_FRAME;
                    end else begin
                        wd_cnt_d = wd_cnt_q + 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (s_tick) begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            last_grant_q  <= GW'(N_REQ - 1);
            grant_id_q    <= '0;
            wd_cnt_q      <= '0;
            gap_cnt_q     <= '0;
            req_ready_q   <= '0;
            req_done_q    <= '0;
            tx_start_q    <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            tx_din_q      <= 8'h00;
            dbit_q        <= 3'b011;
            sbit_q        <= 2'b00;
            parity_q      <= 2'b00;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_id_q    <= grant_id_d;
            wd_cnt_q      <= wd_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            req_ready_q   <= req_ready_d;
            req_done_q    <= req_done_d;
            tx_start_q    <= tx_start_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            tx_din_q      <= tx_din_d;
            dbit_q        <= dbit_d;
            sbit_q        <= sbit_d;
            parity_q      <= parity_d;
        end
    end

    assign req_ready       = req_ready_q;
    assign req_done        = req_done_q;
    assign tx_start        = tx_start_q;
    assign busy            = busy_q;
    assign timeout_err     = timeout_err_q;
    assign grant_id        = grant_id_q;
    assign tx_din          = tx_din_q;
    assign dbit_select_o   = dbit_q;
    assign sbit_select_o   = sbit_q;
    assign parity_select_o = parity_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one instance with a 16-tick gap and 8-tick watchdog,
// a second with no gap for the back-to-back timing.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  valid_a = '0;
    logic [3:0]  valid_b = '0;
    logic [31:0] req_data = '0;
    logic [11:0] req_dbit = '0;
    logic [7:0]  req_sbit = '0;
    logic [7:0]  req_parity = '0;
    logic        s_tick = 1'b0;
    logic        tx_done = 1'b0;

    logic [3:0]  ready_a, done_a, ready_b, done_b;
    logic        start_a, busy_a, tmo_a, start_b, busy_b, tmo_b;
    logic [7:0]  din_a, din_b;
    logic [2:0]  dbit_a, dbit_b;
    logic [1:0]  sbit_a, sbit_b, par_a, par_b, gid_a, gid_b;

    int total = 0;
    int bad = 0;

    typedef struct {
        int         idx;
        logic [7:0] data;
        logic [2:0] dbit;
        logic [1:0] sbit;
        logic [1:0] par;
        logic [2:0] e_dbit;
        logic [1:0] e_sbit;
        logic [1:0] e_par;
    } vec_t;

    vec_t vecs[5];

    uart_tx_arbiter #(.N_REQ(4), .GAP_TICKS(16), .TIMEOUT_TICKS(8)) dut_a (
        .clk(clk), .reset(reset), .req_valid(valid_a), .req_data(req_data),
        .req_dbit(req_dbit), .req_sbit(req_sbit), .req_parity(req_parity),
        .req_ready(ready_a), .req_done(done_a), .s_tick(s_tick), .tx_done_tick(tx_done),
        .tx_start(start_a), .tx_din(din_a), .dbit_select_o(dbit_a), .sbit_select_o(sbit_a),
        .parity_select_o(par_a), .busy(busy_a), .grant_id(gid_a), .timeout_err(tmo_a)
    );

    uart_tx_arbiter #(.N_REQ(4), .GAP_TICKS(0), .TIMEOUT_TICKS(8)) dut_b (
        .clk(clk), .reset(reset), .req_valid(valid_b), .req_data(req_data),
        .req_dbit(req_dbit), .req_sbit(req_sbit), .req_parity(req_parity),
        .req_ready(ready_b), .req_done(done_b), .s_tick(s_tick), .tx_done_tick(tx_done),
        .tx_start(start_b), .tx_din(din_b), .dbit_select_o(dbit_b), .sbit_select_o(sbit_b),
        .parity_select_o(par_b), .busy(busy_b), .grant_id(gid_b), .timeout_err(tmo_b)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        s_tick = 1'b1;
        cyc();
        s_tick = 1'b0;
    endtask

    task automatic gap_a(input int n);
        repeat (n) begin
            cyc();
            tick();
        end
    endtask

    task automatic apply_stimulus(input int idx, input logic [7:0] d, input logic [2:0] db,
                                  input logic [1:0] sb, input logic [1:0] pa);
        for (int i = 0; i < 4; i++) begin
            req_data[8*i +: 8]   = (i == idx) ? d  : ~d;
            req_dbit[3*i +: 3]   = (i == idx) ? db : ~db;
            req_sbit[2*i +: 2]   = (i == idx) ? sb : ~sb;
            req_parity[2*i +: 2] = (i == idx) ? pa : ~pa;
        end
    endtask

    task automatic check_reset_a();
        check_output("rst ready", ready_a, 0);
        check_output("rst done", done_a, 0);
        check_output("rst tx_start", start_a, 0);
        check_output("rst busy", busy_a, 0);
        check_output("rst timeout", tmo_a, 0);
        check_output("rst tx_din", din_a, 0);
        check_output("rst dbit", dbit_a, 3);
        check_output("rst sbit", sbit_a, 0);
        check_output("rst parity", par_a, 0);
        check_output("rst grant_id", gid_a, 0);
    endtask

    // Frame is in BUSY: deliver done, then drain the 16-tick gap.
    task automatic finish_a(input int idx);
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
        check_output("done onehot", done_a, 32'(1 << idx));
        check_output("no timeout", tmo_a, 0);
        gap_a(16);
        check_output("busy after gap", busy_a, 0);
    endtask

    initial begin
        vecs[0] = '{1, 8'hAC, 3'b011, 2'b00, 2'b00, 3'b011, 2'b00, 2'b00};
        vecs[1] = '{2, 8'h55, 3'b010, 2'b10, 2'b01, 3'b010, 2'b10, 2'b01};
        vecs[2] = '{3, 8'h3C, 3'b111, 2'b11, 2'b11, 3'b011, 2'b10, 2'b00};
        vecs[3] = '{0, 8'h0F, 3'b000, 2'b01, 2'b10, 3'b000, 2'b01, 2'b10};
        vecs[4] = '{1, 8'h80, 3'b100, 2'b00, 2'b01, 3'b011, 2'b00, 2'b01};

        reset = 1'b1;
        cyc();
        cyc();
        check_reset_a();
        reset = 1'b0;

        // Single requests with format pass-through and clamping.
        for (int v = 0; v < 5; v++) begin
            apply_stimulus(vecs[v].idx, vecs[v].data, vecs[v].dbit, vecs[v].sbit, vecs[v].par);
            valid_a = 4'(1 << vecs[v].idx);
            cyc();
            check_output("vec ready", ready_a, 32'(1 << vecs[v].idx));
            check_output("vec tx_start", start_a, 1);
            check_output("vec busy", busy_a, 1);
            check_output("vec grant_id", gid_a, 32'(vecs[v].idx));
            check_output("vec tx_din", din_a, 32'(vecs[v].data));
            check_output("vec dbit", dbit_a, 32'(vecs[v].e_dbit));
            check_output("vec sbit", sbit_a, 32'(vecs[v].e_sbit));
            check_output("vec parity", par_a, 32'(vecs[v].e_par));
            valid_a = '0;
            req_data = '1;
            req_dbit = '0;
            req_sbit = '0;
            req_parity = '0;
            cyc();
            check_output("vec start once", start_a, 0);
            check_output("vec din held", din_a, 32'(vecs[v].data));
            check_output("vec dbit held", dbit_a, 32'(vecs[v].e_dbit));
            finish_a(vecs[v].idx);
        end

        // Round robin with all requesters valid continuously.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        req_data = 32'h33221100;
        valid_a = 4'hF;
        for (int g = 0; g < 5; g++) begin
            cyc();
            check_output("rr ready", ready_a, 32'(1 << (g % 4)));
            check_output("rr grant_id", gid_a, 32'(g % 4));
            check_output("rr tx_start", start_a, 1);
            check_output("rr tx_din", din_a, 32'((g % 4) * 8'h11));
            cyc();
            check_output("rr start once", start_a, 0);
            finish_a(g % 4);
        end
        valid_a = '0;

        // Watchdog expiry after 8 ticks in BUSY.
        valid_a = 4'b0100;
        cyc();
        check_output("tmo ready", ready_a, 32'h4);
        valid_a = '0;
        cyc();
        for (int i = 1; i <= 8; i++) begin
            cyc();
            tick();
            if (i < 8) check_output("tmo early", tmo_a, 0);
        end
        check_output("tmo pulse", tmo_a, 1);
        check_output("tmo no done", done_a, 0);
        check_output("tmo busy gap", busy_a, 1);
        cyc();
        check_output("tmo one cycle", tmo_a, 0);
        gap_a(16);
        check_output("tmo idle", busy_a, 0);

        // Next grant is normal; done on the final watchdog tick wins.
        valid_a = 4'b1001;
        cyc();
        check_output("post tmo ready", ready_a, 32'h8);
        valid_a = '0;
        cyc();
        repeat (7) begin
            cyc();
            tick();
        end
        s_tick = 1'b1;
        tx_done = 1'b1;
        cyc();
        s_tick = 1'b0;
        tx_done = 1'b0;
        check_output("race done", done_a, 32'h8);
        check_output("race no timeout", tmo_a, 0);
        gap_a(16);
        check_output("race idle", busy_a, 0);

        // Gap holds off a pending request for exactly 16 ticks.
        valid_a = 4'b0001;
        cyc();
        check_output("gap ready0", ready_a, 32'h1);
        valid_a = 4'b0010;
        cyc();
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
        check_output("gap done0", done_a, 32'h1);
        for (int i = 0; i < 16; i++) begin
            cyc();
            check_output("gap no start", start_a, 0);
            tick();
            check_output("gap no start tick", start_a, 0);
            check_output("gap busy", busy_a, (i < 15) ? 32'h1 : 32'h0);
        end
        cyc();
        check_output("gap start after", start_a, 1);
        check_output("gap ready1", ready_a, 32'h2);
        valid_a = '0;
        cyc();
        finish_a(1);

        // Back-to-back with no gap: next tx_start two cycles after done tick.
        valid_b = 4'b0011;
        cyc();
        check_output("b2b ready0", ready_b, 32'h1);
        check_output("b2b start0", start_b, 1);
        cyc();
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
        check_output("b2b done0", done_b, 32'h1);
        check_output("b2b busy low", busy_b, 0);
        check_output("b2b no start D+1", start_b, 0);
        cyc();
        check_output("b2b start D+2", start_b, 1);
        check_output("b2b ready1", ready_b, 32'h2);
        valid_b = '0;
        cyc();
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
        check_output("b2b done1", done_b, 32'h2);
        cyc();
        check_output("b2b idle", busy_b, 0);

        // Reset while BUSY aborts the frame silently.
        valid_a = 4'b0100;
        cyc();
        check_output("mid ready", ready_a, 32'h4);
        valid_a = '0;
        cyc();
        tick();
        tick();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check_reset_a();
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
        check_output("mid no done", done_a, 0);
        valid_a = 4'hF;
        cyc();
        check_output("mid regrant", ready_a, 32'h1);
        check_output("mid grant_id", gid_a, 0);
        valid_a = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
